run_detector_n: RTL and testbench

RUN_DETECTOR_N -- requirements
Module: run_detector_n

---
 rtl/run_det_pkg.sv | 22 ++
 rtl/sat_counter.sv | 34 +++
 rtl/run_detector_n.sv | 100 ++++++++++
 tb/tb_run_detector_n.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/run_det_pkg.sv
// rtl/run_det_pkg.sv - shared mode encodings and qualifier helpers for run_detector_n
//
// Purpose: mode encodings for the run detector, plus helpers that decide
// which run polarities a mode value qualifies.
package run_det_pkg;

  typedef enum logic [1:0] {
    MODE_BOTH = 2'b00,
    MODE_ZERO = 2'b01,
    MODE_ONE  = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  function automatic logic zero_qualified(input logic [1:0] m);
    return (m == MODE_BOTH) || (m == MODE_ZERO);
  endfunction

  function automatic logic one_qualified(input logic [1:0] m);
    return (m == MODE_BOTH) || (m == MODE_ONE);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts i_inc pulses and holds at all-ones instead of wrapping.
// Ports:
//   clk     - clock, rising edge
//   i_sclr  - synchronous active-high reset
//   i_clr   - synchronous clear; wins over a simultaneous increment
//   i_inc   - increment request
//   o_count - current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_sclr,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_sclr || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/run_detector_n.sv
// rtl/run_detector_n.sv - one-hot run-length detector for zero/one runs
//
// Purpose: tracks the current run of equal serial samples in a one-hot state
// vector and flags runs of at least RUN_LEN samples whose polarity is enabled
// by mode.
// Ports:
//   clk     - clock, rising edge
//   sclr    - synchronous active-high reset
//   en      - sample enable; w is consumed only when high
//   w       - serial data sample
//   mode    - 00 both, 01 zero-runs, 10 one-runs, 11 off
//   clr_cnt - synchronous clear of hit_cnt
//   z       - qualified run detected (combinational from state and mode)
//   hit     - registered one-cycle pulse on entry into a qualified terminal state
//   hit_cnt - saturating count of hit pulses
//   y       - one-hot state: [0] idle, [1..RUN_LEN] zero-runs, [RUN_LEN+1..] one-runs
module run_detector_n
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8,
  localparam int STATE_W = 2 * RUN_LEN + 1
) (
  input  logic               clk,
  input  logic               sclr,
  input  logic               en,
  input  logic               w,
  input  logic [1:0]         mode,
  input  logic               clr_cnt,
  output logic               z,
  output logic               hit,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [STATE_W-1:0] y
);

  localparam int Z_TERM = RUN_LEN;
  localparam int O_TERM = 2 * RUN_LEN;

  logic [STATE_W-1:0] r_y;
  logic [STATE_W-1:0] w_next;
  logic               r_hit;
  logic               w_hit_set;
  logic               w_zero_q;
  logic               w_one_q;

  always_comb begin
    w_next = r_y;
    if (en) begin
      w_next = '0;
      if (!w) begin
        // Idle or any one-run restarts a zero-run at length 1.
        w_next[1] = r_y[0] | (|r_y[O_TERM:RUN_LEN+1]);
        for (int k = 2; k <= RUN_LEN; k++) begin
          w_next[k] = r_y[k-1];
        end
        w_next[Z_TERM] = w_next[Z_TERM] | r_y[Z_TERM];
      end else begin
        w_next[RUN_LEN+1] = r_y[0] | (|r_y[Z_TERM:1]);
        for (int k = 2; k <= RUN_LEN; k++) begin
          w_next[RUN_LEN+k] = r_y[RUN_LEN+k-1];
        end
        w_next[O_TERM] = w_next[O_TERM] | r_y[O_TERM];
      end
    end
  end

  assign w_zero_q = zero_qualified(mode);
  assign w_one_q  = one_qualified(mode);

  // Terminal states are only re-entered from themselves, so "next terminal
  // and not currently terminal" is exactly a fresh entry.
  assign w_hit_set = en &
                     ((w_next[Z_TERM] & ~r_y[Z_TERM] & w_zero_q) |
                      (w_next[O_TERM] & ~r_y[O_TERM] & w_one_q));

  always_ff @(posedge clk) begin
    if (sclr) begin
      r_y   <= STATE_W'(1);
      r_hit <= 1'b0;
    end else begin
      r_y   <= w_next;
      r_hit <= w_hit_set;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_hit_cnt (
    .clk    (clk),
    .i_sclr (sclr),
    .i_clr  (clr_cnt),
    .i_inc  (w_hit_set),
    .o_count(hit_cnt)
  );

  assign z   = (r_y[Z_TERM] & w_zero_q) | (r_y[O_TERM] & w_one_q);
  assign hit = r_hit;
  assign y   = r_y;

endmodule

// File: tb/tb_run_detector_n.sv
// tb/tb_run_detector_n.sv - scoreboard testbench for run_detector_n
module tb_run_detector_n;

  localparam int RUN_LEN = 4;
  localparam int CNT_W   = 4;
  localparam int STATE_W = 2 * RUN_LEN + 1;

  typedef struct packed {
    logic [STATE_W-1:0] y;
    logic               z;
    logic               hit;
    logic [CNT_W-1:0]   cnt;
  } exp_t;

  logic               clk;
  logic               sclr;
  logic               en;
  logic               w;
  logic [1:0]         mode;
  logic               clr_cnt;
  logic               z;
  logic               hit;
  logic [CNT_W-1:0]   hit_cnt;
  logic [STATE_W-1:0] y;

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;

  run_detector_n #(
    .RUN_LEN(RUN_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk    (clk),
    .sclr   (sclr),
    .en     (en),
    .w      (w),
    .mode   (mode),
    .clr_cnt(clr_cnt),
    .z      (z),
    .hit    (hit),
    .hit_cnt(hit_cnt),
    .y      (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // Monitor: the DUT presents a result every cycle; compare at the falling
  // edge against whatever the stimulus pushed for the preceding rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("y",       32'(y),       32'(e.y));
      check("onehot",  32'($onehot(y)), 32'd1);
      check("z",       32'(z),       32'(e.z));
      check("hit",     32'(hit),     32'(e.hit));
      check("hit_cnt", 32'(hit_cnt), 32'(e.cnt));
    end
  end

  task automatic step(input logic i_sclr, input logic i_en, input logic i_w,
                      input logic [1:0] i_mode, input logic i_clr,
                      input logic [STATE_W-1:0] ey, input logic ez,
                      input logic ehit, input logic [CNT_W-1:0] ecnt);
    exp_t e;
    sclr    = i_sclr;
    en      = i_en;
    w       = i_w;
    mode    = i_mode;
    clr_cnt = i_clr;
    @(posedge clk);
    #1;
    e.y = ey; e.z = ez; e.hit = ehit; e.cnt = ecnt;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    sclr = 1'b1; en = 1'b0; w = 1'b0; mode = 2'b00; clr_cnt = 1'b0;
    @(negedge clk);
    #1;

    // Zero run of 6 samples: walk to Z4, saturate, single hit.
    step(1, 0, 0, 2'b00, 0, 9'h001, 0, 0, 0);
    step(0, 1, 0, 2'b00, 0, 9'h002, 0, 0, 0);
    step(0, 1, 0, 2'b00, 0, 9'h004, 0, 0, 0);
    step(0, 1, 0, 2'b00, 0, 9'h008, 0, 0, 0);
    step(0, 1, 0, 2'b00, 0, 9'h010, 1, 1, 1);
    step(0, 1, 0, 2'b00, 0, 9'h010, 1, 0, 1);
    step(0, 1, 0, 2'b00, 0, 9'h010, 1, 0, 1);

    // 1,1,1,0,1,1,1,1: the broken run never detects.
    step(1, 1, 1, 2'b00, 0, 9'h001, 0, 0, 0);
    step(0, 1, 1, 2'b00, 0, 9'h020, 0, 0, 0);
    step(0, 1, 1, 2'b00, 0, 9'h040, 0, 0, 0);
    step(0, 1, 1, 2'b00, 0, 9'h080, 0, 0, 0);
    step(0, 1, 0, 2'b00, 0, 9'h002, 0, 0, 0);
    step(0, 1, 1, 2'b00, 0, 9'h020, 0, 0, 0);
    step(0, 1, 1, 2'b00, 0, 9'h040, 0, 0, 0);
    step(0, 1, 1, 2'b00, 0, 9'h080, 0, 0, 0);
    step(0, 1, 1, 2'b00, 0, 9'h100, 1, 1, 1);

    // mode=10: zero run ignored, one run detected; then mode changes mid-run.
    step(1, 0, 0, 2'b10, 0, 9'h001, 0, 0, 0);
    step(0, 1, 0, 2'b10, 0, 9'h002, 0, 0, 0);
    step(0, 1, 0, 2'b10, 0, 9'h004, 0, 0, 0);
    step(0, 1, 0, 2'b10, 0, 9'h008, 0, 0, 0);
    step(0, 1, 0, 2'b10, 0, 9'h010, 0, 0, 0);
    step(0, 1, 0, 2'b10, 0, 9'h010, 0, 0, 0);
    step(0, 1, 1, 2'b10, 0, 9'h020, 0, 0, 0);
    step(0, 1, 1, 2'b10, 0, 9'h040, 0, 0, 0);
    step(0, 1, 1, 2'b10, 0, 9'h080, 0, 0, 0);
    step(0, 1, 1, 2'b10, 0, 9'h100, 1, 1, 1);
    step(0, 0, 1, 2'b01, 0, 9'h100, 0, 0, 1);
    step(0, 0, 0, 2'b00, 0, 9'h100, 1, 0, 1);
    step(0, 1, 1, 2'b11, 0, 9'h100, 0, 0, 1);

    // Alternating 4-sample runs: 20 detections saturate the 4-bit counter.
    step(1, 0, 0, 2'b00, 0, 9'h001, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < 4; j++) begin
        int base;
        int c;
        base = (i % 2 == 0) ? 1 : 5;
        c = (j == 3) ? i + 1 : i;
        if (c > 15) c = 15;
        step(0, 1, logic'(i % 2), 2'b00, 0, STATE_W'(1) << (base + j),
             logic'(j == 3), logic'(j == 3), CNT_W'(c));
      end
    end
    step(0, 1, 0, 2'b00, 0, 9'h002, 0, 0, 15);
    step(0, 1, 0, 2'b00, 0, 9'h004, 0, 0, 15);
    step(0, 1, 0, 2'b00, 0, 9'h008, 0, 0, 15);
    step(0, 1, 0, 2'b00, 1, 9'h010, 1, 1, 0);
    step(0, 1, 0, 2'b00, 0, 9'h010, 1, 0, 0);

    // en=0 holds the state while w toggles.
    step(1, 0, 0, 2'b00, 0, 9'h001, 0, 0, 0);
    step(0, 1, 0, 2'b00, 0, 9'h002, 0, 0, 0);
    step(0, 1, 0, 2'b00, 0, 9'h004, 0, 0, 0);
    step(0, 1, 0, 2'b00, 0, 9'h008, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, logic'(i % 2 == 0), 2'b00, 0, 9'h008, 0, 0, 0);
    end
    step(0, 1, 0, 2'b00, 0, 9'h010, 1, 1, 1);

    // Reach O4, then sclr overrides an active sample.
    step(0, 1, 1, 2'b00, 0, 9'h020, 0, 0, 1);
    step(0, 1, 1, 2'b00, 0, 9'h040, 0, 0, 1);
    step(0, 1, 1, 2'b00, 0, 9'h080, 0, 0, 1);
    step(0, 1, 1, 2'b00, 0, 9'h100, 1, 1, 2);
    step(1, 1, 1, 2'b00, 0, 9'h001, 0, 0, 0);
    step(0, 1, 1, 2'b00, 0, 9'h020, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
